// File: rtl/dma_copy_master.sv
// dma_copy_master: bus initiator copying len 32-bit words from src_addr to dst_addr in BURST-word chunks
//   clk, reset_n (async, active-low)
//   start, src_addr, dst_addr, len : copy request, latched in IDLE
//   bus_req / bus_gnt              : bus ownership handshake with the bus mux
//   rd, wr, addr, wdata            : memory bus strobes, driven only while granted
//   rdata, accessable              : combinational responder data and access-valid flag
//   busy, done, err, err_addr      : status; err/err_addr hold until the next accepted start
module dma_copy_master #(
  parameter int BURST = 4,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             rd,
  output logic             wr,
  output logic [31:0]      addr,
  output logic [31:0]      wdata,
  input  logic [31:0]      rdata,
  input  logic             accessable,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      err_addr
);
  localparam int IW = BURST > 1 ? $clog2(BURST) : 1;
  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ERR} state_t;
  state_t           state;
  logic [31:0]      src_ptr, dst_ptr;
  logic [LEN_W-1:0] rem;
  logic [IW-1:0]    idx;
  logic [31:0]      mem [BURST];
  logic             rd_last, wr_last;
  assign bus_req = state == READ || state == WRITE;
  assign rd      = state == READ && bus_gnt;
  assign wr      = state == WRITE && bus_gnt;
  assign addr    = rd ? src_ptr : wr ? dst_ptr : '0;
  assign wdata   = wr ? mem[idx] : '0;
  // rem only shrinks during writes, so during READ it still holds the chunk's remaining count
  assign rd_last = idx == IW'(BURST - 1) || LEN_W'(idx) == rem - LEN_W'(1);
  assign wr_last = idx == IW'(BURST - 1) || rem == LEN_W'(1);
  always_ff @(posedge clk)
    if (state == READ && bus_gnt && accessable) mem[idx] <= rdata;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      rem      <= '0;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          src_ptr  <= src_addr;
          dst_ptr  <= dst_addr;
          rem      <= len;
          idx      <= '0;
          busy     <= 1'b1;
          err      <= 1'b0;
          err_addr <= '0;
          if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
            err      <= 1'b1;
            done     <= 1'b1;
            err_addr <= src_addr[1:0] != 2'b00 ? src_addr : dst_addr;
            state    <= ERR;
          end else if (len == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else state <= READ;
        end
        READ: if (bus_gnt) begin
          if (!accessable) begin
            err      <= 1'b1;
            done     <= 1'b1;
            err_addr <= src_ptr;
            state    <= ERR;
          end else begin
            src_ptr <= src_ptr + 32'd4;
            idx     <= rd_last ? '0 : idx + IW'(1);
            if (rd_last) state <= WRITE;
          end
        end
        WRITE: if (bus_gnt) begin
          if (!accessable) begin
            err      <= 1'b1;
            done     <= 1'b1;
            err_addr <= dst_ptr;
            state    <= ERR;
          end else begin
            dst_ptr <= dst_ptr + 32'd4;
            rem     <= rem - LEN_W'(1);
            idx     <= wr_last ? '0 : idx + IW'(1);
            if (wr_last) begin
              done  <= rem == LEN_W'(1);
              state <= rem == LEN_W'(1) ? DONE : READ;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dma_copy_master.sv
// tb_dma_copy_master: randomized copies against a queue-based copy model with a memory responder
module tb_dma_copy_master;
  localparam int BURST = 4;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, bus_gnt = 1'b1;
  logic [31:0] src_addr = '0, dst_addr = '0, rdata;
  logic [15:0] len = '0;
  logic        bus_req, rd, wr, accessable, busy, done, err;
  logic [31:0] addr, wdata, err_addr;
  logic [31:0] mem_act [3072];
  logic [31:0] mem_exp [3072];
  logic [65:0] obs [$];
  logic [65:0] exp_q [$];
  int          total = 0, bad = 0, wi;

  dma_copy_master #(.BURST(BURST), .LEN_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .bus_req(bus_req), .bus_gnt(bus_gnt), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .accessable(accessable), .busy(busy), .done(done),
    .err(err), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  // data window 0x10010000..0x10010fff and stack window 0x7fffe000..0x7fffffff
  function automatic int widx(input logic [31:0] a);
    if (a >= 32'h10010000 && a < 32'h10011000) return int'((a - 32'h10010000) >> 2);
    if (a >= 32'h7fffe000 && a < 32'h80000000) return 1024 + int'((a - 32'h7fffe000) >> 2);
    return -1;
  endfunction

  always_comb begin
    wi = widx(addr);
    accessable = wi >= 0;
    rdata = accessable ? mem_act[wi] : 32'h0;
  end

  always @(posedge clk) if (wr && accessable) mem_act[wi] <= wdata;

  always @(negedge clk) if (rd || wr) obs.push_back({rd, wr, addr, wdata});

  // forward copy in chunks of BURST: all reads of a chunk, then its writes; stops at the first fault
  function automatic void model(input logic [31:0] s, d, input int n, output int ops,
                                output logic e, output logic [31:0] ea);
    logic [31:0] tmp [$];
    logic [31:0] a;
    int base, c;
    exp_q.delete();
    ops = 0; e = 1'b0; ea = '0; base = 0;
    if (s[1:0] != 0) begin e = 1'b1; ea = s; return; end
    if (d[1:0] != 0) begin e = 1'b1; ea = d; return; end
    while (base < n) begin
      c = (n - base < BURST) ? n - base : BURST;
      tmp.delete();
      for (int i = 0; i < c; i++) begin
        a = s + 32'(4 * (base + i));
        ops++;
        exp_q.push_back({2'b10, a, 32'h0});
        if (widx(a) < 0) begin e = 1'b1; ea = a; return; end
        tmp.push_back(mem_exp[widx(a)]);
      end
      for (int i = 0; i < c; i++) begin
        a = d + 32'(4 * (base + i));
        ops++;
        exp_q.push_back({2'b01, a, tmp[i]});
        if (widx(a) < 0) begin e = 1'b1; ea = a; return; end
        mem_exp[widx(a)] = tmp[i];
      end
      base += c;
    end
  endfunction

  function automatic int ops_diff();
    int m = (obs.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) if (obs[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int mem_diff();
    int m = 0;
    for (int i = 0; i < 3072; i++) if (mem_act[i] !== mem_exp[i]) m++;
    return m;
  endfunction

  // one copy; cyc counts cycles after the start edge until done is seen
  task automatic run(input logic [31:0] s, d, input int n, input int stall_at, input int pulse_at,
                     output int cyc, output int stall_bad, output int busy_bad);
    obs.delete();
    stall_bad = 0; busy_bad = 0; cyc = 1;
    @(negedge clk);
    src_addr = s; dst_addr = d; len = 16'(n); start = 1'b1;
    @(posedge clk); #1;
    forever begin
      start = cyc == pulse_at;
      src_addr = start ? 32'h20000000 : s;
      bus_gnt = !(stall_at > 0 && cyc >= stall_at && cyc < stall_at + 5);
      @(negedge clk);
      if (!bus_gnt && (rd || wr || addr != 0)) stall_bad++;
      if (!busy) busy_bad++;
      if (done || cyc >= 400) break;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; bus_gnt = 1'b1; src_addr = s;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if ({busy, done, err, bus_req, rd, wr} !== 6'b0) begin bad++;
      $display("FAIL reset_flags got=%b exp=000000", {busy, done, err, bus_req, rd, wr}); end
    total++; if (addr !== 0 || wdata !== 0 || err_addr !== 0) begin bad++;
      $display("FAIL reset_bus addr=%h wdata=%h err_addr=%h exp=0", addr, wdata, err_addr); end
    reset_n = 1'b1;
  endtask

  task automatic test_copy3();
    int cyc, sb, bb, ops; logic e; logic [31:0] ea;
    logic [31:0] v [3];
    v[0] = 32'h11; v[1] = 32'h22; v[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      mem_act[widx(32'h10010000 + 32'(4 * i))] = v[i];
      mem_exp[widx(32'h10010000 + 32'(4 * i))] = v[i];
    end
    model(32'h10010000, 32'h10010100, 3, ops, e, ea);
    run(32'h10010000, 32'h10010100, 3, 0, 0, cyc, sb, bb);
    total++; if (cyc !== 7) begin bad++; $display("FAIL copy3_latency got=%0d exp=7", cyc); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL copy3_err got=%b exp=0", err); end
    for (int i = 0; i < 3; i++) begin
      total++; if (mem_act[widx(32'h10010100 + 32'(4 * i))] !== v[i]) begin bad++;
        $display("FAIL copy3_word%0d got=%h exp=%h", i, mem_act[widx(32'h10010100 + 32'(4 * i))], v[i]); end
    end
    total++; if (ops_diff() != 0) begin bad++; $display("FAIL copy3_ops got=%0d exp=%0d", obs.size(), ops); end
    total++; if (bb != 0) begin bad++; $display("FAIL copy3_busy low_cycles got=%0d exp=0", bb); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL copy3_after busy=%b done=%b exp=0 0", busy, done); end
  endtask

  task automatic test_copy10();
    int cyc, sb, bb, ops, k, mm; logic e; logic [31:0] ea;
    int runs [$];
    int er [6];
    er = '{4, 4, 4, 4, 2, 2};
    model(32'h10010200, 32'h10010800, 10, ops, e, ea);
    run(32'h10010200, 32'h10010800, 10, 0, 0, cyc, sb, bb);
    total++; if (cyc !== 21) begin bad++; $display("FAIL copy10_latency got=%0d exp=21", cyc); end
    for (int i = 0; i < obs.size(); i++) begin
      if (i == 0 || obs[i][65:64] != obs[i-1][65:64]) runs.push_back(1);
      else begin k = runs.pop_back(); runs.push_back(k + 1); end
    end
    mm = (runs.size() != 6 || obs.size() == 0 || obs[0][65:64] != 2'b10) ? 1 : 0;
    for (int i = 0; i < runs.size() && i < 6; i++) if (runs[i] != er[i]) mm++;
    total++; if (mm != 0) begin bad++; $display("FAIL copy10_pattern got_runs=%0d exp=R4W4R4W4R2W2", runs.size()); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL copy10_data got=%0d bad_words exp=0", mem_diff()); end
    total++; if (ops_diff() != 0) begin bad++; $display("FAIL copy10_ops got=%0d exp=%0d", obs.size(), ops); end
  endtask

  task automatic test_fault();
    int cyc, sb, bb, ops, nwr; logic e; logic [31:0] ea;
    model(32'h7fffeffc, 32'h10010a00, 2, ops, e, ea);
    run(32'h7fffeffc, 32'h10010a00, 2, 0, 0, cyc, sb, bb);
    total++; if (err !== 1'b0 || cyc !== 5) begin bad++; $display("FAIL stack_copy err=%b cyc=%0d exp=0 5", err, cyc); end
    total++; if (mem_diff() != 0) begin bad++; $display("FAIL stack_data got=%0d bad_words exp=0", mem_diff()); end
    model(32'h20000000, 32'h10010a00, 3, ops, e, ea);
    run(32'h20000000, 32'h10010a00, 3, 0, 0, cyc, sb, bb);
    nwr = 0;
    foreach (obs[i]) if (obs[i][64]) nwr++;
    total++; if (err !== 1'b1 || err_addr !== 32'h20000000) begin bad++;
      $display("FAIL src_fault err=%b err_addr=%h exp=1 20000000", err, err_addr); end
    total++; if (nwr != 0 || cyc != ops + 1) begin bad++;
      $display("FAIL src_fault_bus writes=%0d cyc=%0d exp=0 %0d", nwr, cyc, ops + 1); end
    model(32'h10010000, 32'h10010ff8, 4, ops, e, ea);
    run(32'h10010000, 32'h10010ff8, 4, 0, 0, cyc, sb, bb);
    total++; if (err !== e || err_addr !== ea || cyc != ops + 1) begin bad++;
      $display("FAIL dst_fault err=%b err_addr=%h cyc=%0d exp=%b %h %0d", err, err_addr, cyc, e, ea, ops + 1); end
    total++; if (mem_diff() != 0 || ops_diff() != 0) begin bad++;
      $display("FAIL dst_fault_data words=%0d ops=%0d exp=0 0", mem_diff(), ops_diff()); end
  endtask

  task automatic test_misaligned();
    int cyc, sb, bb, ops; logic e; logic [31:0] ea;
    model(32'h10010000, 32'h10010002, 3, ops, e, ea);
    run(32'h10010000, 32'h10010002, 3, 0, 0, cyc, sb, bb);
    total++; if (err !== 1'b1 || err_addr !== 32'h10010002) begin bad++;
      $display("FAIL misaligned err=%b err_addr=%h exp=1 10010002", err, err_addr); end
    total++; if (cyc != 1 || obs.size() != 0) begin bad++;
      $display("FAIL misaligned_bus cyc=%0d ops=%0d exp=1 0", cyc, obs.size()); end
    run(32'h10010000, 32'h10010100, 0, 0, 0, cyc, sb, bb);
    total++; if (cyc != 1 || obs.size() != 0 || err !== 1'b0) begin bad++;
      $display("FAIL len0 cyc=%0d ops=%0d err=%b exp=1 0 0", cyc, obs.size(), err); end
  endtask

  task automatic test_random();
    int cyc, sb, bb, ops, n, st; logic e; logic [31:0] ea, s, d;
    for (int t = 0; t < 6; t++) begin
      n = $urandom_range(1, 20);
      s = 32'h10010000 + 32'($urandom_range(0, 900)) * 4;
      d = 32'h10010000 + 32'($urandom_range(0, 900)) * 4;
      st = $urandom_range(0, 2 * n);
      model(s, d, n, ops, e, ea);
      run(s, d, n, st, 0, cyc, sb, bb);
      total++; if (cyc != ops + 1 + (st > 0 ? 5 : 0) || err !== 1'b0) begin bad++;
        $display("FAIL rand%0d_latency got=%0d err=%b exp=%0d 0", t, cyc, err, ops + 1 + (st > 0 ? 5 : 0)); end
      total++; if (ops_diff() != 0 || mem_diff() != 0) begin bad++;
        $display("FAIL rand%0d_data ops=%0d words=%0d exp=0 0", t, ops_diff(), mem_diff()); end
      total++; if (sb != 0 || bb != 0) begin bad++;
        $display("FAIL rand%0d_ctl stall_bus=%0d busy_low=%0d exp=0 0", t, sb, bb); end
    end
  endtask

  task automatic test_grant_stall();
    int cyc, sb, bb, ops; logic e; logic [31:0] ea;
    model(32'h10010300, 32'h10010400, 8, ops, e, ea);
    run(32'h10010300, 32'h10010400, 8, 6, 0, cyc, sb, bb);
    total++; if (cyc != 22) begin bad++; $display("FAIL stall_latency got=%0d exp=22", cyc); end
    total++; if (sb != 0) begin bad++; $display("FAIL stall_bus active_cycles=%0d exp=0", sb); end
    total++; if (mem_diff() != 0 || ops_diff() != 0) begin bad++;
      $display("FAIL stall_data words=%0d ops=%0d exp=0 0", mem_diff(), ops_diff()); end
  endtask

  task automatic test_reset_mid();
    int cyc, sb, bb, ops; logic e; logic [31:0] ea;
    @(negedge clk);
    src_addr = 32'h10010500; dst_addr = 32'h10010600; len = 16'd8; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    total++; if (rd !== 1'b1) begin bad++; $display("FAIL midreset_active rd=%b exp=1", rd); end
    reset_n = 1'b0;
    #1;
    total++; if ({busy, rd, wr, done, bus_req} !== 5'b0) begin bad++;
      $display("FAIL midreset_clear got=%b exp=00000", {busy, rd, wr, done, bus_req}); end
    @(negedge clk) reset_n = 1'b1;
    model(32'h10010500, 32'h10010600, 8, ops, e, ea);
    run(32'h10010500, 32'h10010600, 8, 0, 3, cyc, sb, bb);
    total++; if (cyc != 17 || err !== 1'b0 || bb != 0) begin bad++;
      $display("FAIL restart cyc=%0d err=%b busy_low=%0d exp=17 0 0", cyc, err, bb); end
    total++; if (mem_diff() != 0 || ops_diff() != 0) begin bad++;
      $display("FAIL restart_data words=%0d ops=%0d exp=0 0", mem_diff(), ops_diff()); end
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) mem_act[i] = $urandom;
    mem_exp = mem_act;
    test_reset();
    test_copy3();
    test_copy10();
    test_fault();
    test_misaligned();
    test_random();
    test_grant_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dma_copy_master.md
Name: dma_copy_master

Overview:
- Bus initiator for the data-memory bus; the DataMem/peripheral side is the responder.
- Copies a block of 32-bit words from a source address to a destination address using the same signals: rd, wr, addr, wdata, rdata and accessable.
- Sits beside the CPU and takes the bus through a req/gnt handshake with the bus mux.
- Buffers up to BURST words per chunk.

Parameters:
- BURST, 4: words read into the internal buffer before they are written out; power of 2, at least 1.
- LEN_W, 16: width of the word-count input.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled in IDLE only.
- src_addr  in  32  source byte address; latched on start.
- dst_addr  in  32  destination byte address; latched on start.
- len  in  LEN_W  number of words to copy; latched on start.
- bus_req  out  1  requests bus ownership.
- bus_gnt  in  1  bus granted this cycle.
- rd  out  1  read strobe to the memory bus.
- wr  out  1  write strobe; the responder commits the write on the posedge.
- addr  out  32  bus address.
- wdata  out  32  write data.
- rdata  in  32  combinational read data, valid in the same cycle as addr/rd.
- accessable  in  1  combinational; 1 = the current address is valid for the current access.
- busy  out  1  high from the cycle after start until the cycle after done.
- done  out  1  one-cycle pulse at completion, on success or error.
- err  out  1  sticky fault flag; cleared by the next accepted start.
- err_addr  out  32  faulting bus address.

Behaviour:
- Reset (asynchronous): state = IDLE. All outputs are 0; internal pointers, counters and buffer index are 0.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE:
  - On start=1, latch src, dst and len, clear err, and go to READ.
  - Exceptions: src[1:0] or dst[1:0] nonzero → ERR with err_addr = the misaligned address (src is checked first). len = 0 → DONE.
  - start outside IDLE is ignored.
- bus_req = 1 in READ and WRITE. rd, wr and addr are driven only when bus_gnt = 1; otherwise rd = wr = 0, addr = 0, and the state holds (stall). Loss of grant mid-chunk pauses the copy and loses no data.
- READ, gnt = 1:
  - Drive rd = 1, addr = src_ptr.
  - If accessable = 1: buf[idx] <= rdata, src_ptr += 4, idx += 1.
  - If accessable = 0: go to ERR with err_addr = src_ptr.
  - chunk = min(BURST, remaining). After chunk reads, reset idx to 0 and go to WRITE.
- WRITE, gnt = 1:
  - Drive wr = 1, addr = dst_ptr, wdata = buf[idx].
  - If accessable = 1: dst_ptr += 4, idx += 1, remaining −= 1.
  - If accessable = 0: go to ERR with err_addr = dst_ptr. Words already written stay written.
  - After chunk writes: remaining = 0 → DONE, otherwise → READ.
- DONE: done = 1 for one cycle, then IDLE.
- ERR: err <= 1, done = 1 for one cycle, then IDLE. err and err_addr hold until the next accepted start.
- Address arithmetic: 32-bit, wraps modulo 2^32 with no fault of its own; the responder's accessable decides validity.
- Overlapping ranges: defined only as a chunked forward copy of BURST words at a time; no overlap detection.
- wdata is 0 whenever wr = 0.
- Latency with gnt held high and N words: done is high in cycle 2N + 1 + (number of READ↔WRITE turnarounds already counted in those 2N), i.e. exactly 2N + 1 cycles after the start edge.
  - N reads and N writes are interleaved in chunks of BURST.
  - busy drops in the cycle after done.

Test Plan:
- Copy of 3 words: global 0x10010000..08 = {0x11, 0x22, 0x33}, dst = 0x10010100, gnt = 1 → reads then writes. dst holds {0x11, 0x22, 0x33}; done is high 7 cycles after start; err = 0.
- Copy of 10 words with BURST = 4 → rd/wr pattern R4 W4 R4 W4 R2 W2. All 10 words match; done arrives at cycle 21.
- Fault: src = 0x7fffeffc (stack word), len = 2 → the second read hits 0x7ffff000 with accessable = 1; a separate case uses src = 0x20000000 → ERR. In the second case err = 1, err_addr = 0x20000000, done pulses, and no wr is ever asserted.
- Misaligned: dst = 0x10010002 → no rd/wr issued; err = 1, err_addr = 0x10010002, done 1 cycle after start.
- Grant stall: drop bus_gnt for 5 cycles in the middle of the WRITE phase → rd = wr = 0 during the stall. Data is still correct and done is delayed by exactly 5 cycles.
- Reset mid-copy: assert reset_n = 0 during READ → busy, rd, wr and done go to 0 immediately. A new start then completes normally, and start pulses while busy are ignored.
